// File: rtl/rv_mem_pkg.sv
// Shared definitions for the RV32I memory-access stage: funct3/RegSrc codes,
// FSM state encoding and the EX-field record carried through to write-back.
package rv_mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] RS_ALU   = 2'd0;
   localparam logic [1:0] RS_DMEM  = 2'd1;
   localparam logic [1:0] RS_PCIMM = 2'd2;
   localparam logic [1:0] RS_PC4   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] pc_imm;
      logic [31:0] pc;
      logic [2:0]  funct3;
      logic [1:0]  regsrc;
   } ex_rec_t;

   function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
      if (is_store) return f3 inside {F3_SB, F3_SH, F3_SW};
      return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
   endfunction

endpackage

// File: rtl/store_align.sv
// Byte-lane enables, lane-shifted store data and misalignment detect for one
// load/store access; purely combinational.
module store_align
   import rv_mem_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic        is_store_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] rs2_i,
   output logic [3:0]  we_o,
   output logic [31:0] wdata_o,
   output logic        misaligned_o
);

   always_comb begin
      we_o    = 4'b0000;
      wdata_o = rs2_i << {off_i, 3'b000};
      case (funct3_i[1:0])
         2'b00:   we_o = 4'b0001 << off_i;
         2'b01:   we_o = 4'b0011 << off_i;
         default: we_o = 4'b1111;
      endcase
      // Undefined width codes are reported as misaligned so memory is never touched.
      misaligned_o = !f3_legal(funct3_i, is_store_i)
                  || (funct3_i[1:0] == 2'b01 && off_i[0])
                  || (funct3_i[1:0] == 2'b10 && off_i != 2'b00);
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: accepts one EX result per handshake, runs a single load/store on
// the data-memory port and presents registered write-back fields.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | ready for EX; non-mem/misaligned ops complete from here
//   ST_REQ  | dmem_en pulse with address/lanes/data on the port
//   ST_WAIT | waiting for dmem_rvalid, bus error after TIMEOUT cycles
module mem_access_stage
   import rv_mem_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [31:0]       ex_alu_result,
   input  logic [31:0]       ex_pc_imm,
   input  logic [31:0]       ex_pc,
   input  logic [2:0]        ex_funct3,
   input  logic [1:0]        ex_regsrc,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic [31:0]       ex_rs2_data,
   output logic              dmem_en,
   output logic [3:0]        dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_rvalid,
   output logic              wb_valid,
   output logic [31:0]       wb_alu_result,
   output logic [31:0]       wb_pc_imm,
   output logic [31:0]       wb_pc,
   output logic [2:0]        wb_funct3,
   output logic [1:0]        wb_regsrc,
   output logic [31:0]       wb_dmem_word,
   output logic              wb_misaligned,
   output logic              wb_bus_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   ex_rec_t           pend_q;
   ex_rec_t           wb_q;
   logic              is_load_q;
   logic              dmem_en_q;
   logic [3:0]        dmem_we_q;
   logic [ADDR_W-1:0] dmem_addr_q;
   logic [31:0]       dmem_wdata_q;
   logic              wb_valid_q;
   logic [31:0]       wb_word_q;
   logic              wb_mis_q;
   logic              wb_err_q;

   logic              mem_op;
   logic [3:0]        sa_we;
   logic [31:0]       sa_wdata;
   logic              sa_mis;
   ex_rec_t           ex_rec;

   assign mem_op = ex_mem_read | ex_mem_write;
   assign ex_rec = '{alu: ex_alu_result, pc_imm: ex_pc_imm, pc: ex_pc,
                     funct3: ex_funct3, regsrc: ex_regsrc};

   store_align u_store_align (
      .funct3_i     (ex_funct3),
      .is_store_i   (ex_mem_write),
      .off_i        (ex_alu_result[1:0]),
      .rs2_i        (ex_rs2_data),
      .we_o         (sa_we),
      .wdata_o      (sa_wdata),
      .misaligned_o (sa_mis)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         pend_q       <= '0;
         wb_q         <= '0;
         is_load_q    <= 1'b0;
         dmem_en_q    <= 1'b0;
         dmem_we_q    <= 4'b0000;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         wb_valid_q   <= 1'b0;
         wb_word_q    <= '0;
         wb_mis_q     <= 1'b0;
         wb_err_q     <= 1'b0;
      end else begin
         wb_valid_q <= 1'b0;
         dmem_en_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (ex_valid) begin
                  if (mem_op && !sa_mis) begin
                     pend_q       <= ex_rec;
                     is_load_q    <= !ex_mem_write;
                     dmem_en_q    <= 1'b1;
                     dmem_we_q    <= ex_mem_write ? sa_we : 4'b0000;
                     dmem_addr_q  <= ex_alu_result[ADDR_W+1:2];
                     dmem_wdata_q <= ex_mem_write ? sa_wdata : 32'd0;
                     state_q      <= ST_REQ;
                  end else begin
                     wb_q       <= ex_rec;
                     wb_word_q  <= 32'd0;
                     wb_mis_q   <= mem_op;
                     wb_err_q   <= 1'b0;
                     wb_valid_q <= 1'b1;
                  end
               end
            end
            ST_REQ: state_q <= ST_WAIT;
            ST_WAIT: begin
               // A response on the last allowed cycle still wins over the timeout.
               if (dmem_rvalid) begin
                  wb_q       <= pend_q;
                  wb_word_q  <= is_load_q ? dmem_rdata : 32'd0;
                  wb_mis_q   <= 1'b0;
                  wb_err_q   <= 1'b0;
                  wb_valid_q <= 1'b1;
                  cnt_q      <= '0;
                  state_q    <= ST_IDLE;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  wb_q       <= pend_q;
                  wb_word_q  <= 32'd0;
                  wb_mis_q   <= 1'b0;
                  wb_err_q   <= 1'b1;
                  wb_valid_q <= 1'b1;
                  cnt_q      <= '0;
                  state_q    <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ex_ready      = (state_q == ST_IDLE);
   assign dmem_en       = dmem_en_q;
   assign dmem_we       = dmem_we_q;
   assign dmem_addr     = dmem_addr_q;
   assign dmem_wdata    = dmem_wdata_q;
   assign wb_valid      = wb_valid_q;
   assign wb_alu_result = wb_q.alu;
   assign wb_pc_imm     = wb_q.pc_imm;
   assign wb_pc         = wb_q.pc;
   assign wb_funct3     = wb_q.funct3;
   assign wb_regsrc     = wb_q.regsrc;
   assign wb_dmem_word  = wb_word_q;
   assign wb_misaligned = wb_mis_q;
   assign wb_bus_err    = wb_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized and directed bench for mem_access_stage against an
// access-level reference model (width/offset arithmetic, response timing).
module tb_mem_access_stage;
   import rv_mem_pkg::*;

   localparam int ADDR_W  = 12;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              ex_valid;
   logic              ex_ready;
   logic [31:0]       ex_alu_result, ex_pc_imm, ex_pc, ex_rs2_data;
   logic [2:0]        ex_funct3;
   logic [1:0]        ex_regsrc;
   logic              ex_mem_read, ex_mem_write;
   logic              dmem_en;
   logic [3:0]        dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [31:0]       dmem_wdata, dmem_rdata;
   logic              dmem_rvalid;
   logic              wb_valid;
   logic [31:0]       wb_alu_result, wb_pc_imm, wb_pc, wb_dmem_word;
   logic [2:0]        wb_funct3;
   logic [1:0]        wb_regsrc;
   logic              wb_misaligned, wb_bus_err;

   int checks = 0;
   int errors = 0;

   mem_access_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_alu_result(ex_alu_result), .ex_pc_imm(ex_pc_imm), .ex_pc(ex_pc),
      .ex_funct3(ex_funct3), .ex_regsrc(ex_regsrc),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_rs2_data(ex_rs2_data),
      .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
      .wb_valid(wb_valid), .wb_alu_result(wb_alu_result), .wb_pc_imm(wb_pc_imm),
      .wb_pc(wb_pc), .wb_funct3(wb_funct3), .wb_regsrc(wb_regsrc),
      .wb_dmem_word(wb_dmem_word), .wb_misaligned(wb_misaligned),
      .wb_bus_err(wb_bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference: an access of 'bytes' width must sit on a multiple of 'bytes'.
   function automatic bit model_mis(input logic [2:0] f3, input bit is_store,
                                    input logic [31:0] addr);
      int unsigned bytes;
      bit legal;
      legal = is_store ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (!legal) return 1'b1;
      bytes = 32'd1 << f3[1:0];
      return (addr % bytes) != 0;
   endfunction

   task automatic check_wb(input string name, input logic [31:0] alu, pcimm, pc,
                           input logic [2:0] f3, input logic [1:0] rs,
                           input logic [31:0] word, input bit mis, err);
      check({name, ".wb_valid"}, 32'(wb_valid), 32'd1);
      check({name, ".wb_alu"},   wb_alu_result, alu);
      check({name, ".wb_pcimm"}, wb_pc_imm, pcimm);
      check({name, ".wb_pc"},    wb_pc, pc);
      check({name, ".wb_f3"},    32'(wb_funct3), 32'(f3));
      check({name, ".wb_rs"},    32'(wb_regsrc), 32'(rs));
      check({name, ".wb_word"},  wb_dmem_word, word);
      check({name, ".wb_mis"},   32'(wb_misaligned), 32'(mis));
      check({name, ".wb_err"},   32'(wb_bus_err), 32'(err));
   endtask

   task automatic drive_ex(input logic [31:0] alu, pcimm, pc, input logic [2:0] f3,
                           input logic [1:0] rs, input bit rd, wr, input logic [31:0] rs2);
      ex_valid = 1'b1;
      ex_alu_result = alu; ex_pc_imm = pcimm; ex_pc = pc;
      ex_funct3 = f3; ex_regsrc = rs;
      ex_mem_read = rd; ex_mem_write = wr; ex_rs2_data = rs2;
   endtask

   task automatic scramble_ex();
      ex_valid = 1'b0;
      ex_alu_result = $urandom; ex_pc_imm = $urandom; ex_pc = $urandom;
      ex_funct3 = 3'($urandom); ex_regsrc = 2'($urandom);
      ex_mem_read = 1'($urandom); ex_mem_write = 1'($urandom); ex_rs2_data = $urandom;
   endtask

   // d = WAIT cycles before the response (0 = one cycle after dmem_en), -1 = never.
   task automatic run_op(input string name, input logic [31:0] alu, pcimm, pc,
                         input logic [2:0] f3, input logic [1:0] rs, input bit rd, wr,
                         input logic [31:0] rs2, input int d, input logic [31:0] rdata);
      bit mem, mis, touches, done;
      int unsigned off, bytes;
      logic [3:0]  we_e;
      logic [31:0] wd_e, word_e;
      mem     = rd | wr;
      mis     = mem && model_mis(f3, wr, alu);
      touches = mem && !mis;
      off     = 32'(alu[1:0]);
      bytes   = 32'd1 << f3[1:0];
      we_e    = wr ? 4'(((32'd1 << bytes) - 1) << off) : 4'h0;
      wd_e    = wr ? (rs2 << (8 * off)) : 32'd0;

      @(negedge clk);
      check({name, ".ready"}, 32'(ex_ready), 32'd1);
      drive_ex(alu, pcimm, pc, f3, rs, rd, wr, rs2);
      @(posedge clk); #1;
      if (!touches) begin
         check({name, ".no_en"}, 32'(dmem_en), 32'd0);
         check_wb(name, alu, pcimm, pc, f3, rs, 32'd0, mis, 1'b0);
      end else begin
         check({name, ".en"},    32'(dmem_en), 32'd1);
         check({name, ".addr"},  32'(dmem_addr), (alu >> 2) & ((32'd1 << ADDR_W) - 1));
         check({name, ".we"},    32'(dmem_we), 32'(we_e));
         if (wr) check({name, ".wdata"}, dmem_wdata, wd_e);
         check({name, ".busy"},  32'(ex_ready), 32'd0);
         check({name, ".no_wb"}, 32'(wb_valid), 32'd0);
         @(negedge clk);
         scramble_ex();
         dmem_rvalid = 1'($urandom);
         dmem_rdata  = $urandom;
         @(posedge clk); #1;
         check({name, ".en_pulse"}, 32'(dmem_en), 32'd0);
         check({name, ".req_wb"},   32'(wb_valid), 32'd0);
         done = 1'b0;
         for (int k = 0; k < TIMEOUT && !done; k++) begin
            @(negedge clk);
            dmem_rvalid = (k == d);
            dmem_rdata  = (k == d) ? rdata : $urandom;
            @(posedge clk); #1;
            check({name, ".wait_en"}, 32'(dmem_en), 32'd0);
            if (k == d || k == TIMEOUT - 1) begin
               word_e = (k == d && rd && !wr) ? rdata : 32'd0;
               check_wb(name, alu, pcimm, pc, f3, rs, word_e, 1'b0, k != d);
               done = 1'b1;
            end else begin
               check({name, ".wait_wb"}, 32'(wb_valid), 32'd0);
            end
         end
      end
      @(negedge clk);
      scramble_ex();
      dmem_rvalid = (d < 0) ? 1'b1 : 1'($urandom);
      dmem_rdata  = $urandom;
      @(posedge clk); #1;
      check({name, ".pulse1"},  32'(wb_valid), 32'd0);
      check({name, ".idle"},    32'(ex_ready), 32'd1);
      check({name, ".hold"},    wb_alu_result, alu);
      check({name, ".late_en"}, 32'(dmem_en), 32'd0);
      @(negedge clk);
      dmem_rvalid = 1'b0;
   endtask

   task automatic reset_mid(input string name, input int wait_cycles);
      @(negedge clk);
      drive_ex(32'h0000_0010, 32'h1, 32'h2, F3_LW, RS_DMEM, 1'b1, 1'b0, 32'h0);
      @(posedge clk); #1;
      check({name, ".en_before"}, 32'(dmem_en), 32'd1);
      if (wait_cycles > 0) begin
         @(negedge clk);
         scramble_ex();
         repeat (wait_cycles) @(posedge clk);
         #1;
      end
      #2 rst = 1'b1;
      #1;
      check({name, ".en"},    32'(dmem_en), 32'd0);
      check({name, ".wb"},    32'(wb_valid), 32'd0);
      check({name, ".ready"}, 32'(ex_ready), 32'd1);
      check({name, ".wbalu"}, wb_alu_result, 32'd0);
      @(negedge clk);
      scramble_ex();
      rst = 1'b0;
      @(posedge clk); #1;
      check({name, ".no_wb"}, 32'(wb_valid), 32'd0);
   endtask

   initial begin
      logic [2:0] f3;
      int kind, d;
      bit rd, wr;
      rst = 1'b1;
      ex_valid = 1'b0; ex_alu_result = '0; ex_pc_imm = '0; ex_pc = '0;
      ex_funct3 = '0; ex_regsrc = '0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
      ex_rs2_data = '0; dmem_rdata = '0; dmem_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      check("rst.ready", 32'(ex_ready), 32'd1);
      check("rst.en",    32'(dmem_en), 32'd0);
      check("rst.we",    32'(dmem_we), 32'd0);
      check("rst.addr",  32'(dmem_addr), 32'd0);
      check("rst.wdata", dmem_wdata, 32'd0);
      check("rst.wbv",   32'(wb_valid), 32'd0);
      check("rst.word",  wb_dmem_word, 32'd0);
      check("rst.err",   32'(wb_bus_err), 32'd0);
      rst = 1'b0;

      run_op("alu",    32'h1234, 32'h50, 32'h40, 3'd0, RS_ALU, 1'b0, 1'b0, 32'h0, 0, 32'h0);
      run_op("sh",     32'h102, 32'h0, 32'h44, F3_SH, RS_ALU, 1'b0, 1'b1, 32'hAABBCCDD, 0, 32'h0);
      run_op("lw",     32'h8, 32'h0, 32'h48, F3_LW, RS_DMEM, 1'b1, 1'b0, 32'h0, 0, 32'hDEADBEEF);
      run_op("lw_mis", 32'h6, 32'h0, 32'h4C, F3_LW, RS_DMEM, 1'b1, 1'b0, 32'h0, 0, 32'h0);
      run_op("lb_to",  32'h21, 32'h0, 32'h50, F3_LB, RS_DMEM, 1'b1, 1'b0, 32'h0, -1, 32'h0);
      run_op("lhu_lst",32'hFFFF_F00E, 32'h0, 32'h54, F3_LHU, RS_PC4, 1'b1, 1'b0, 32'h0,
             TIMEOUT - 1, 32'h1357_9BDF);
      run_op("sb_rw",  32'h7, 32'h0, 32'h58, F3_SB, RS_PCIMM, 1'b1, 1'b1, 32'h1122_3344, 2,
             32'hFFFF_FFFF);
      run_op("bad_f3", 32'h0, 32'h0, 32'h5C, 3'd3, RS_ALU, 1'b0, 1'b1, 32'h0, 0, 32'h0);
      reset_mid("rst_req", 0);
      run_op("after_r1", 32'h20, 32'h0, 32'h60, F3_LW, RS_DMEM, 1'b1, 1'b0, 32'h0, 3, 32'hCAFE_F00D);
      reset_mid("rst_wait", 4);
      run_op("after_r2", 32'h24, 32'h0, 32'h64, F3_LBU, RS_DMEM, 1'b1, 1'b0, 32'h0, 0, 32'h0BAD_F00D);

      for (int n = 0; n < 150; n++) begin
         kind = $urandom_range(0, 3);
         rd = (kind == 1) || (kind == 3);
         wr = (kind == 2) || (kind == 3);
         if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
         else if (wr) f3 = 3'($urandom_range(0, 2));
         else begin
            case ($urandom_range(0, 4))
               0: f3 = F3_LB;
               1: f3 = F3_LH;
               2: f3 = F3_LW;
               3: f3 = F3_LBU;
               default: f3 = F3_LHU;
            endcase
         end
         d = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, TIMEOUT - 1);
         run_op("rnd", $urandom, $urandom, $urandom, f3, 2'($urandom), rd, wr,
                $urandom, d, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
